// File: rtl/gpio_reg_pkg.sv
// Register-file side types for the GPIO block, plus the shared definitions
// used by the data_in write arbiter.
package gpio_reg_pkg;

  // Width of the GPIO data_in register
  localparam int unsigned GpioDataW = 32'd32;

  // Hardware write port of the data_in register: value plus write strobe
  typedef struct packed {
    logic [GpioDataW-1:0] d;
    logic                 de;
  } gpio_hw2reg_data_in_reg_t;

  // Complete hardware-to-register bundle (data_in is the only hw-written field)
  typedef struct packed {
    gpio_hw2reg_data_in_reg_t data_in;
  } gpio_hw2reg_t;

  // Alternate name kept for existing users of the bundle
  typedef gpio_hw2reg_t gpio_hw2reg_tt;

  // Write sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } gpio_arb_state_e;

endpackage

// File: rtl/gpio_rr_pick.sv
// Combinational round-robin picker: selects the first set request at or
// after ptr, searching upward and wrapping modulo NumReq.
module gpio_rr_pick
  import gpio_reg_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   idx
);

  logic [IdxW-1:0] cand_s;
  logic            found_s;
  logic            hit_s;

  // Walk the requests starting at ptr; the first hit wins and masks later ones
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    cand_s  = '0;
    for (int i = 32'sd0; i < NumReq; i++) begin
      cand_s      = IdxW'((int'(ptr) + i) % NumReq);
      hit_s       = !found_s && req[cand_s];
      gnt[cand_s] = hit_s;
      idx         = hit_s ? cand_s : idx;
      found_s     = found_s | hit_s;
    end
  end

endmodule

// File: rtl/gpio_data_in_arb.sv
// Round-robin arbiter and write sequencer for the single hardware write
// port of the GPIO data_in register. One source is accepted per slot, its
// value is registered and presented with a one-cycle de strobe, optionally
// followed by a quiet gap of MinGap cycles.
module gpio_data_in_arb
  import gpio_reg_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int MinGap = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq*GpioDataW-1:0] data_i,
  output logic [NumReq-1:0]           gnt_o,
  output gpio_hw2reg_t                hw2reg_o,
  output logic                        busy_o
);

  localparam int IdxW    = $clog2(NumReq);
  localparam int GapBits = $clog2(MinGap + 32'sd1);
  localparam int GapW    = (GapBits < 32'sd1) ? 32'sd1 : GapBits;
  localparam logic [GapW-1:0] GapLoad = GapW'(MinGap);
  localparam logic [GapW-1:0] GapOne  = GapW'(32'd1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 32'sd1);
  // With no gap, the strobe cycle doubles as a grant slot
  localparam bit ZeroGap = (MinGap == 32'sd0);

  gpio_arb_state_e       state_r;
  gpio_arb_state_e       state_next_s;
  logic [IdxW-1:0]       rr_ptr_r;
  logic [IdxW-1:0]       rr_ptr_next_s;
  logic [GpioDataW-1:0]  d_r;
  logic                  de_r;
  logic                  busy_r;
  logic [GapW-1:0]       gap_cnt_r;
  logic [GapW-1:0]       gap_cnt_next_s;
  logic [NumReq-1:0]     pick_gnt_s;
  logic [IdxW-1:0]       pick_idx_s;
  logic                  grant_en_s;
  logic                  accept_s;
  logic [GpioDataW-1:0]  win_data_s;

  gpio_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .req (req_i),
    .ptr (rr_ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s)
  );

  // Grant window: open in IDLE, and in WRITE only when no gap is configured
  always_comb begin
    grant_en_s = 1'b0;
    if (rst_i) begin
      grant_en_s = 1'b0;
    end else if (state_r == IDLE) begin
      grant_en_s = 1'b1;
    end else if ((state_r == WRITE) && ZeroGap) begin
      grant_en_s = 1'b1;
    end else begin
      grant_en_s = 1'b0;
    end
  end

  // Grant, accept detection, winner data and the advanced pointer
  always_comb begin
    gnt_o         = grant_en_s ? pick_gnt_s : '0;
    accept_s      = |(req_i & gnt_o);
    win_data_s    = data_i[int'(pick_idx_s)*GpioDataW +: GpioDataW];
    rr_ptr_next_s = (pick_idx_s == LastIdx) ? '0 : (pick_idx_s + 1'b1);
  end

  // Next-state and gap counter logic
  always_comb begin
    state_next_s   = state_r;
    gap_cnt_next_s = gap_cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = WRITE;
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITE: begin
        if (ZeroGap) begin
          if (accept_s) begin
            state_next_s = WRITE;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s   = GAP;
          gap_cnt_next_s = GapLoad;
        end
      end
      GAP: begin
        if (gap_cnt_r <= GapOne) begin
          state_next_s   = IDLE;
          gap_cnt_next_s = '0;
        end else begin
          state_next_s   = GAP;
          gap_cnt_next_s = gap_cnt_r - GapOne;
        end
      end
      default: begin
        state_next_s   = IDLE;
        gap_cnt_next_s = '0;
      end
    endcase
  end

  // State, pointer, captured data and registered strobe/busy outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      rr_ptr_r  <= '0;
      d_r       <= '0;
      de_r      <= 1'b0;
      busy_r    <= 1'b0;
      gap_cnt_r <= '0;
    end else begin
      state_r   <= state_next_s;
      gap_cnt_r <= gap_cnt_next_s;
      de_r      <= accept_s;
      busy_r    <= (state_next_s != IDLE);
      if (accept_s) begin
        d_r      <= win_data_s;
        rr_ptr_r <= rr_ptr_next_s;
      end else begin
        d_r      <= d_r;
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  assign hw2reg_o.data_in.d  = d_r;
  assign hw2reg_o.data_in.de = de_r;
  assign busy_o              = busy_r;

endmodule

// File: tb/tb_gpio_data_in_arb.sv
// Self-checking bench for gpio_data_in_arb: one instance without a gap and
// one with MinGap = 3. Expected strobe data is queued at accept time and
// compared when the strobe appears.
module tb_gpio_data_in_arb;
  import gpio_reg_pkg::*;

  logic         clk;
  logic         rst;
  logic [3:0]   req0, req3;
  logic [127:0] data0, data3;
  logic [3:0]   gnt0, gnt3;
  gpio_hw2reg_t h0, h3;
  logic         busy0, busy3;

  logic [31:0]  src0 [4];
  logic [31:0]  src3 [4];
  logic [31:0]  exp_q [$];
  logic [31:0]  exp_d;
  int           pass_cnt = 0;
  int           total_cnt = 0;

  assign data0 = {src0[3], src0[2], src0[1], src0[0]};
  assign data3 = {src3[3], src3[2], src3[1], src3[0]};

  gpio_data_in_arb #(.NumReq(4), .MinGap(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .data_i(data0),
    .gnt_o(gnt0), .hw2reg_o(h0), .busy_o(busy0)
  );

  gpio_data_in_arb #(.NumReq(4), .MinGap(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .data_i(data3),
    .gnt_o(gnt3), .hw2reg_o(h3), .busy_o(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_all();
    @(posedge clk); #1;
    rst = 1'b1; req0 = 4'b0000; req3 = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    req0 = 4'b1111; req3 = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total_cnt++; if (gnt0 !== 4'b0000) $display("FAIL rst_gnt0[%0d]: got %b want 0000", c, gnt0); else pass_cnt++;
      total_cnt++; if (gnt3 !== 4'b0000) $display("FAIL rst_gnt3[%0d]: got %b want 0000", c, gnt3); else pass_cnt++;
      total_cnt++; if (h0 !== 33'd0) $display("FAIL rst_hw2reg[%0d]: got %h want 0", c, h0); else pass_cnt++;
      total_cnt++; if (busy0 !== 1'b0) $display("FAIL rst_busy[%0d]: got %b want 0", c, busy0); else pass_cnt++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (gnt0 !== 4'b0001) $display("FAIL rst_first_gnt0: got %b want 0001", gnt0); else pass_cnt++;
    total_cnt++; if (gnt3 !== 4'b0001) $display("FAIL rst_first_gnt3: got %b want 0001", gnt3); else pass_cnt++;
    exp_q.push_back(src0[0]);
    @(posedge clk); #1;
    req0 = 4'b0000; req3 = 4'b0000;
    @(negedge clk);
    if (exp_q.size() > 0) exp_d = exp_q.pop_front(); else exp_d = 32'hxxxx_xxxx;
    total_cnt++; if (h0.data_in.de !== 1'b1) $display("FAIL rst_first_de: got %b want 1", h0.data_in.de); else pass_cnt++;
    total_cnt++; if (h0.data_in.d !== exp_d) $display("FAIL rst_first_d: got %h want %h", h0.data_in.d, exp_d); else pass_cnt++;
    total_cnt++; if (busy0 !== 1'b1) $display("FAIL rst_first_busy: got %b want 1", busy0); else pass_cnt++;
  endtask

  task automatic test_single();
    reset_all();
    src0[2] = 32'hDEADBEEF;
    req0 = 4'b0100;
    @(negedge clk);
    total_cnt++; if (gnt0 !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", gnt0); else pass_cnt++;
    exp_q.push_back(32'hDEADBEEF);
    @(posedge clk); #1;
    req0 = 4'b0000;
    @(negedge clk);
    if (exp_q.size() > 0) exp_d = exp_q.pop_front(); else exp_d = 32'hxxxx_xxxx;
    total_cnt++; if (h0.data_in.de !== 1'b1) $display("FAIL single_de: got %b want 1", h0.data_in.de); else pass_cnt++;
    total_cnt++; if (h0.data_in.d !== exp_d) $display("FAIL single_d: got %h want %h", h0.data_in.d, exp_d); else pass_cnt++;
    @(posedge clk); #1;
    src0[2] = $urandom;
    @(negedge clk);
    total_cnt++; if (h0.data_in.de !== 1'b0) $display("FAIL single_de_off: got %b want 0", h0.data_in.de); else pass_cnt++;
    total_cnt++; if (h0.data_in.d !== 32'hDEADBEEF) $display("FAIL single_d_hold: got %h want deadbeef", h0.data_in.d); else pass_cnt++;
    total_cnt++; if (busy0 !== 1'b0) $display("FAIL single_busy_off: got %b want 0", busy0); else pass_cnt++;
  endtask

  task automatic test_fairness();
    reset_all();
    req0 = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total_cnt++; if (gnt0 !== (4'b0001 << (i % 4))) $display("FAIL fair_gnt[%0d]: got %b want %b", i, gnt0, 4'b0001 << (i % 4)); else pass_cnt++;
      if (i > 0) begin
        if (exp_q.size() > 0) exp_d = exp_q.pop_front(); else exp_d = 32'hxxxx_xxxx;
        total_cnt++; if (h0.data_in.de !== 1'b1) $display("FAIL fair_de[%0d]: got %b want 1", i, h0.data_in.de); else pass_cnt++;
        total_cnt++; if (h0.data_in.d !== exp_d) $display("FAIL fair_d[%0d]: got %h want %h", i, h0.data_in.d, exp_d); else pass_cnt++;
      end
      exp_q.push_back(src0[i % 4]);
      @(posedge clk); #1;
      src0[i % 4] = $urandom;
    end
    req0 = 4'b0000;
    @(negedge clk);
    if (exp_q.size() > 0) exp_d = exp_q.pop_front(); else exp_d = 32'hxxxx_xxxx;
    total_cnt++; if (h0.data_in.d !== exp_d) $display("FAIL fair_d_last: got %h want %h", h0.data_in.d, exp_d); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL fair_queue: got %0d entries want 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_gap();
    reset_all();
    req3 = 4'b1010;
    @(negedge clk);
    total_cnt++; if (gnt3 !== 4'b0010) $display("FAIL gap_gnt_first: got %b want 0010", gnt3); else pass_cnt++;
    exp_q.push_back(src3[1]);
    @(posedge clk); #1;
    req3 = 4'b1000;
    src3[1] = $urandom;
    @(negedge clk);
    if (exp_q.size() > 0) exp_d = exp_q.pop_front(); else exp_d = 32'hxxxx_xxxx;
    total_cnt++; if (h3.data_in.de !== 1'b1) $display("FAIL gap_de_first: got %b want 1", h3.data_in.de); else pass_cnt++;
    total_cnt++; if (h3.data_in.d !== exp_d) $display("FAIL gap_d_first: got %h want %h", h3.data_in.d, exp_d); else pass_cnt++;
    total_cnt++; if (gnt3 !== 4'b0000) $display("FAIL gap_gnt_write: got %b want 0000", gnt3); else pass_cnt++;
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total_cnt++; if (gnt3 !== 4'b0000) $display("FAIL gap_gnt_t%0d: got %b want 0000", c, gnt3); else pass_cnt++;
      total_cnt++; if (h3.data_in.de !== 1'b0) $display("FAIL gap_de_t%0d: got %b want 0", c, h3.data_in.de); else pass_cnt++;
      total_cnt++; if (busy3 !== 1'b1) $display("FAIL gap_busy_t%0d: got %b want 1", c, busy3); else pass_cnt++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++; if (gnt3 !== 4'b1000) $display("FAIL gap_gnt_second: got %b want 1000", gnt3); else pass_cnt++;
    total_cnt++; if (busy3 !== 1'b0) $display("FAIL gap_busy_idle: got %b want 0", busy3); else pass_cnt++;
    exp_q.push_back(src3[3]);
    @(posedge clk); #1;
    req3 = 4'b0000;
    @(negedge clk);
    if (exp_q.size() > 0) exp_d = exp_q.pop_front(); else exp_d = 32'hxxxx_xxxx;
    total_cnt++; if (h3.data_in.de !== 1'b1) $display("FAIL gap_de_second: got %b want 1", h3.data_in.de); else pass_cnt++;
    total_cnt++; if (h3.data_in.d !== exp_d) $display("FAIL gap_d_second: got %h want %h", h3.data_in.d, exp_d); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [3:0] tab_req [8];
    logic [3:0] tab_gnt [8];
    int k;
    // Pointer after each step: 3, 2, 2, 3, 0, 1, 2, 1
    tab_req = '{4'b0100, 4'b0010, 4'b0010, 4'b1111, 4'b1011, 4'b0011, 4'b0011, 4'b0001};
    tab_gnt = '{4'b0100, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0001};
    reset_all();
    for (int s = 0; s < 8; s++) begin
      req0 = tab_req[s];
      @(negedge clk);
      total_cnt++; if (gnt0 !== tab_gnt[s]) $display("FAIL wrap_gnt[%0d]: got %b want %b", s, gnt0, tab_gnt[s]); else pass_cnt++;
      if (s > 0) begin
        if (exp_q.size() > 0) exp_d = exp_q.pop_front(); else exp_d = 32'hxxxx_xxxx;
        total_cnt++; if (h0.data_in.d !== exp_d) $display("FAIL wrap_d[%0d]: got %h want %h", s, h0.data_in.d, exp_d); else pass_cnt++;
      end
      k = $clog2(tab_gnt[s]);
      exp_q.push_back(src0[k]);
      @(posedge clk); #1;
      src0[k] = $urandom;
    end
    req0 = 4'b0000;
    @(negedge clk);
    if (exp_q.size() > 0) exp_d = exp_q.pop_front(); else exp_d = 32'hxxxx_xxxx;
    total_cnt++; if (h0.data_in.d !== exp_d) $display("FAIL wrap_d_last: got %h want %h", h0.data_in.d, exp_d); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    reset_all();
    req0 = 4'b0001;
    @(negedge clk);
    total_cnt++; if (gnt0 !== 4'b0001) $display("FAIL rmid_gnt: got %b want 0001", gnt0); else pass_cnt++;
    exp_q.push_back(src0[0]);
    @(posedge clk); #1;
    rst = 1'b1; req0 = 4'b1111;
    @(negedge clk);
    if (exp_q.size() > 0) exp_d = exp_q.pop_front(); else exp_d = 32'hxxxx_xxxx;
    total_cnt++; if (gnt0 !== 4'b0000) $display("FAIL rmid_gnt_in_rst: got %b want 0000", gnt0); else pass_cnt++;
    total_cnt++; if (h0.data_in.de !== 1'b1) $display("FAIL rmid_de_visible: got %b want 1", h0.data_in.de); else pass_cnt++;
    total_cnt++; if (h0.data_in.d !== exp_d) $display("FAIL rmid_d_visible: got %h want %h", h0.data_in.d, exp_d); else pass_cnt++;
    @(posedge clk); #1;
    req0 = 4'b0000;
    @(negedge clk);
    total_cnt++; if (h0.data_in.de !== 1'b0) $display("FAIL rmid_de_cleared: got %b want 0", h0.data_in.de); else pass_cnt++;
    total_cnt++; if (h0.data_in.d !== 32'd0) $display("FAIL rmid_d_cleared: got %h want 0", h0.data_in.d); else pass_cnt++;
    total_cnt++; if (busy0 !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy0); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (h0.data_in.de !== 1'b0) $display("FAIL rmid_de_after: got %b want 0", h0.data_in.de); else pass_cnt++;
    total_cnt++; if (gnt0 !== 4'b0000) $display("FAIL rmid_gnt_after: got %b want 0000", gnt0); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 4'b0000;
    req3 = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      src0[i] = $urandom;
      src3[i] = $urandom;
    end
    test_reset();
    test_single();
    test_fairness();
    test_gap();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
